// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
// Imported by the interface, the next-PC logic and the top.
package pc_fetch_pkg;

  localparam int XLEN       = 64;
  localparam int INST_BYTES = 4;
  localparam int INST_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } state_t;

  // A taken branch must land on a word boundary.
  function automatic logic
    is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bundle.
// The fetch unit is the master, the memory the slave.
interface pc_fetch_if
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = pc_fetch_pkg::XLEN
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC select: pc+4 or branch target,
// plus the alignment check on a taken branch.
module pc_next_logic
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = pc_fetch_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] branch_target,
  input  logic            branch_taken,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

  // Sequential address wraps naturally modulo 2^XLEN.
  assign pc_plus4 = pc + STEP;

  assign misaligned = branch_taken
    && is_misaligned(branch_target[1:0]);

  assign pc_next = branch_taken
    ? branch_target
    : pc_plus4;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding fetch FSM.
// Issues one request, captures its word, holds it until consumed.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN     = pc_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  pc_fetch_if.master        bus,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              branch_taken,
  input  logic              stall,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              misalign_fault,
  output logic [31:0]       inst_count
);

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic              misaligned;
  logic              req_valid;
  logic              consume;

  pc_next_logic #(
    .XLEN (XLEN)
  ) u_next (
    .pc            (pc),
    .branch_target (branch_target),
    .branch_taken  (branch_taken),
    .pc_plus4      (pc_plus4),
    .pc_next       (pc_next),
    .misaligned    (misaligned)
  );

  // Branch inputs only matter on the consume cycle.
  assign consume = (state == HOLD) && !stall;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = req_valid ? pc : '0;
  assign pc_out             = pc;

  // Fetch FSM with registered request/instruction outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      inst           <= '0;
      inst_valid     <= 1'b0;
      req_valid      <= 1'b0;
      misalign_fault <= 1'b0;
      inst_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state     <= REQ;
          req_valid <= 1'b1;
        end
        REQ: begin
          if (bus.imem_req_ready) begin
            state     <= WAIT;
            req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            inst       <= bus.imem_rsp_data;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            inst_valid <= 1'b0;
            if (misaligned) begin
              misalign_fault <= 1'b1;
              state          <= FAULT;
            end else begin
              pc         <= pc_next;
              inst_count <= inst_count + 32'd1;
              req_valid  <= 1'b1;
              state      <= REQ;
            end
          end
        end
        FAULT: begin
          req_valid  <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit.
// Vector table of consumes plus reset/fault sequences.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] branch_target;
  logic        branch_taken;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc_out;
  logic [63:0] pc_plus4;
  logic        misalign_fault;
  logic [31:0] inst_count;

  pc_fetch_if #(.XLEN(64)) bus ();

  pc_fetch_unit #(
    .XLEN     (64),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .branch_target  (branch_target),
    .branch_taken   (branch_taken),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .misalign_fault (misalign_fault),
    .inst_count     (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic        mem_en;
  logic        inject;
  logic        pending;
  logic [63:0] p_addr;
  logic [63:0] m_pc;
  logic [31:0] m_cnt;

  typedef struct {
    logic        taken;
    logic [63:0] target;
    int          stall_n;
    int          nrdy;
    logic [63:0] exp_next;
    logic [63:0] exp_plus4;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Memory model and request scoreboard, both on the falling edge.
  initial begin
    pending = 1'b0;
    p_addr  = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%h expected=none",
                   bus.imem_addr);
        end else begin
          chk("req_addr", bus.imem_addr, exp_q.pop_front());
        end
      end
      bus.imem_rsp_valid = (pending && mem_en) || inject;
      bus.imem_rsp_data  = inject ? 32'hDEAD_BEEF : mem_word(p_addr);
      pending = bus.imem_req_valid && bus.imem_req_ready;
      p_addr  = bus.imem_addr;
    end
  end

  task automatic wait_hold();
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (inst_valid) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout actual=0 expected=1");
    end
  endtask

  task automatic chk_hold();
    chk("hold_pc", pc_out, m_pc);
    chk("hold_inst", {32'h0, inst}, {32'h0, mem_word(m_pc)});
    chk("hold_plus4", pc_plus4, m_pc + 64'd4);
    chk("hold_count", {32'h0, inst_count}, {32'h0, m_cnt});
  endtask

  task automatic chk_reset();
    chk("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_addr", bus.imem_addr, 64'h0);
    chk("rst_pc", pc_out, 64'h0);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("rst_count", {32'h0, inst_count}, 64'h0);
    chk("rst_fault", {63'h0, misalign_fault}, 64'h0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 64'h0, 0, 0, 64'h4, 64'h8};
    vecs[1] = '{1'b0, 64'h102, 5, 0, 64'h8, 64'hC};
    vecs[2] = '{1'b1, 64'h100, 1, 2, 64'h100, 64'h104};
    vecs[3] = '{1'b1, 64'h40, 0, 0, 64'h40, 64'h44};
    vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1,
                64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[5] = '{1'b0, 64'h0, 0, 0, 64'h0, 64'h4};
    vecs[6] = '{1'b0, 64'h8, 2, 0, 64'h4, 64'h8};

    reset              = 1'b1;
    stall              = 1'b1;
    branch_taken       = 1'b0;
    branch_target      = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    mem_en             = 1'b1;
    inject             = 1'b0;
    m_pc               = '0;
    m_cnt              = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    exp_q.push_back(64'h0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      wait_hold();
      chk_hold();
      repeat (vecs[k].stall_n) begin
        @(posedge clk);
        #1;
        chk("stall_pc", pc_out, m_pc);
        chk("stall_inst", {32'h0, inst}, {32'h0, mem_word(m_pc)});
        chk("stall_count", {32'h0, inst_count}, {32'h0, m_cnt});
        chk("stall_valid", {63'h0, inst_valid}, 64'h1);
        chk("stall_noreq", {63'h0, bus.imem_req_valid}, 64'h0);
      end
      stall         = 1'b0;
      branch_taken  = vecs[k].taken;
      branch_target = vecs[k].target;
      exp_q.push_back(vecs[k].exp_next);
      @(posedge clk);
      #1;
      stall         = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 64'h3;
      m_pc  = vecs[k].exp_next;
      m_cnt = m_cnt + 32'd1;
      chk("cons_valid", {63'h0, inst_valid}, 64'h0);
      chk("cons_pc", pc_out, m_pc);
      chk("cons_plus4", pc_plus4, vecs[k].exp_plus4);
      chk("cons_count", {32'h0, inst_count}, {32'h0, m_cnt});
      if (vecs[k].nrdy > 0) begin
        bus.imem_req_ready = 1'b0;
        repeat (vecs[k].nrdy) begin
          @(posedge clk);
          #1;
          chk("rdy_lo_valid", {63'h0, bus.imem_req_valid}, 64'h1);
          chk("rdy_lo_addr", bus.imem_addr, m_pc);
        end
        bus.imem_req_ready = 1'b1;
      end
    end

    // Misaligned taken branch: terminal fault.
    wait_hold();
    chk_hold();
    stall         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'h102;
    @(posedge clk);
    #1;
    stall        = 1'b1;
    branch_taken = 1'b0;
    inject       = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("flt_flag", {63'h0, misalign_fault}, 64'h1);
      chk("flt_noreq", {63'h0, bus.imem_req_valid}, 64'h0);
      chk("flt_valid", {63'h0, inst_valid}, 64'h0);
      chk("flt_pc", pc_out, m_pc);
      chk("flt_count", {32'h0, inst_count}, {32'h0, m_cnt});
      @(posedge clk);
      #1;
      inject = 1'b0;
      stall  = c[0];
    end
    stall = 1'b1;

    // Reset clears the fault; then reset again mid-WAIT.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mem_en = 1'b0;
    m_pc   = '0;
    m_cnt  = '0;
    chk_reset();
    exp_q.push_back(64'h0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (bus.imem_req_valid) begin
          seen = 1;
          break;
        end
      end
      chk("req_seen", {63'h0, seen}, 64'h1);
    end
    @(posedge clk);
    #1;
    chk("in_wait", {63'h0, bus.imem_req_valid}, 64'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    inject = 1'b1;
    exp_q.push_back(64'h0);
    @(posedge clk);
    #1;
    inject = 1'b0;
    mem_en = 1'b1;
    chk("late_valid", {63'h0, inst_valid}, 64'h0);
    chk("late_inst", {32'h0, inst}, 64'h0);
    chk("restart_req", {63'h0, bus.imem_req_valid}, 64'h1);
    chk("restart_addr", bus.imem_addr, 64'h0);
    wait_hold();
    chk_hold();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    exp_q.push_back(64'h4);
    @(posedge clk);
    #1;
    stall = 1'b1;
    m_pc  = 64'h4;
    m_cnt = 32'd1;
    wait_hold();
    chk_hold();
    chk("q_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Parameter XLEN, default 64, SHALL be the PC/address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 branch_target  input  XLEN  SHALL carry the branch adder sum (PC + sign-extended offset).
REQ-006 branch_taken  input  1  SHALL select branch_target as the next PC when high at consume.
REQ-007 stall  input  1  SHALL hold the current instruction when high.
REQ-008 imem_req_valid  output  1  SHALL flag a valid fetch request.
REQ-009 imem_req_ready  input  1  SHALL accept the request when high together with imem_req_valid.
REQ-010 imem_addr  output  XLEN  SHALL equal pc while imem_req_valid is high; otherwise 0.
REQ-011 imem_rsp_valid  input  1  SHALL qualify imem_rsp_data.
REQ-012 imem_rsp_data  input  32  SHALL carry the fetched instruction word.
REQ-013 inst_valid  output  1  SHALL flag that inst holds an instruction for pc_out.
REQ-014 inst  output  32  SHALL hold the captured instruction.
REQ-015 pc_out  output  XLEN  SHALL be the current PC; drives the branch adder PC input.
REQ-016 pc_plus4  output  XLEN  SHALL be pc_out + 4, modulo 2^XLEN.
REQ-017 misalign_fault  output  1  SHALL be a sticky fault flag.
REQ-018 inst_count  output  32  SHALL count consumed instructions.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, HOLD, FAULT.
REQ-020 IDLE -> REQ unconditionally on the first cycle after reset deasserts.
REQ-021 REQ: imem_req_valid=1; on imem_req_ready=1 -> WAIT; else stay in REQ with address stable.
REQ-022 WAIT: on imem_rsp_valid=1 capture imem_rsp_data into inst, set inst_valid -> HOLD.
REQ-023 HOLD: inst_valid=1; stall=1 stays in HOLD with inst and pc_out unchanged.
REQ-024 HOLD with stall=0 is a consume: pc <= branch_taken ? branch_target : pc+4; inst_count++; inst_valid<=0; -> REQ.
REQ-025 Fetch latency SHALL be 1 cycle from request accept to the earliest HOLD, plus memory response delay.
REQ-026 branch_taken and branch_target SHALL be ignored outside a consume cycle.
REQ-027 On a consume with branch_taken=1 and branch_target[1:0]!=0: pc unchanged, misalign_fault<=1, -> FAULT.
REQ-028 FAULT SHALL be terminal until reset: imem_req_valid=0, inst_valid=0.
REQ-029 imem_rsp_valid outside WAIT SHALL be ignored, including late responses after reset.
REQ-030 pc+4 SHALL wrap: 64'hFFFF_FFFF_FFFF_FFFC -> 64'h0; inst_count wraps 32'hFFFF_FFFF -> 0.
REQ-031 stall=1 outside HOLD SHALL have no effect.

Reset
REQ-032 On reset: pc=RESET_PC, state=IDLE, inst=0, inst_valid=0, imem_req_valid=0, misalign_fault=0, inst_count=0.
REQ-033 Reset in any state, including mid-WAIT, SHALL abandon the outstanding fetch with no retry.

Structure
REQ-034 Shared package pc_fetch_pkg SHALL hold XLEN, INST_BYTES=4, and the FSM state typedef.
REQ-035 One sub-module, pc_next_logic (combinational pc+4 and branch/sequential select plus alignment check), SHALL be instantiated.

Verification
REQ-036 Reset then imem always ready with a 1-cycle response, RESET_PC=0, no branches -> imem_addr sequence 0x0, 0x4, 0x8; inst_count=3 after three consumes.
REQ-037 At pc=0x100, consume with branch_taken=1 and branch_target=0x40 -> next imem_addr=0x40; pc_plus4=0x44.
REQ-038 stall=1 for 5 cycles in HOLD -> inst/pc_out constant; inst_count unchanged; no request issued.
REQ-039 branch_target=0x102 with branch_taken=1 at consume -> misalign_fault=1, FSM in FAULT, imem_req_valid stays 0 until reset.
REQ-040 pc=64'hFFFF_FFFF_FFFF_FFFC, sequential consume -> imem_addr=0x0.
REQ-041 reset asserted in WAIT, with imem_rsp_valid arriving the following cycle -> response ignored; inst_valid=0; fetch restarts at RESET_PC.
